// File: rtl/ibex_pkg.sv
// ibex_pkg: shared PMP types plus the CSR addresses and FSM encoding used by
// the PMP CSR back end (ibex_pmp_csr).
//   pmp_cfg_mode_e  - address-matching mode of a region (A field)
//   pmp_cfg_t       - decoded per-region config {L, A, X, W, R}
//   pmp_mseccfg_t   - machine security config {rlb, mmwp, mml}
//   CSR_*           - CSR addresses served by the PMP CSR back end
//   pmp_csr_state_e - handshake FSM states of the PMP CSR back end
package ibex_pkg;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } pmp_mseccfg_t;

    localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
    localparam logic [11:0] CSR_PMPCFG1   = 12'h3A1;
    localparam logic [11:0] CSR_PMPCFG2   = 12'h3A2;
    localparam logic [11:0] CSR_PMPCFG3   = 12'h3A3;
    localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
    localparam logic [11:0] CSR_PMPADDR1  = 12'h3B1;
    localparam logic [11:0] CSR_PMPADDR2  = 12'h3B2;
    localparam logic [11:0] CSR_PMPADDR3  = 12'h3B3;
    localparam logic [11:0] CSR_PMPADDR4  = 12'h3B4;
    localparam logic [11:0] CSR_PMPADDR5  = 12'h3B5;
    localparam logic [11:0] CSR_PMPADDR6  = 12'h3B6;
    localparam logic [11:0] CSR_PMPADDR7  = 12'h3B7;
    localparam logic [11:0] CSR_PMPADDR8  = 12'h3B8;
    localparam logic [11:0] CSR_PMPADDR9  = 12'h3B9;
    localparam logic [11:0] CSR_PMPADDR10 = 12'h3BA;
    localparam logic [11:0] CSR_PMPADDR11 = 12'h3BB;
    localparam logic [11:0] CSR_PMPADDR12 = 12'h3BC;
    localparam logic [11:0] CSR_PMPADDR13 = 12'h3BD;
    localparam logic [11:0] CSR_PMPADDR14 = 12'h3BE;
    localparam logic [11:0] CSR_PMPADDR15 = 12'h3BF;
    localparam logic [11:0] CSR_MSECCFG   = 12'h747;
    localparam logic [11:0] CSR_MSECCFGH  = 12'h757;

    typedef enum logic [1:0] {
        PMP_CSR_IDLE,
        PMP_CSR_RESP,
        PMP_CSR_FLUSH
    } pmp_csr_state_e;

    // Architectural byte layout is {L, 2'b0, A[1:0], X, W, R}.
    function automatic logic [7:0] cfg_to_byte(input pmp_cfg_t c);
        return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
    endfunction

    function automatic pmp_cfg_t byte_to_cfg(input logic [7:0] b);
        pmp_cfg_t c;
        c.lock  = b[7];
        c.mode  = pmp_cfg_mode_e'(b[4:3]);
        c.exec  = b[2];
        c.write = b[1];
        c.read  = b[0];
        return c;
    endfunction

endpackage

// File: rtl/ibex_pmp_cfg_legalise.sv
// ibex_pmp_cfg_legalise: combinational WARL legalisation of one pmpcfg byte.
// Ports:
//   i_cfg_old  - currently stored config of the region
//   i_cfg_new  - raw byte written by software
//   i_mml      - machine-mode lockdown currently active
//   i_rlb      - rule-locking bypass currently active
//   i_locked   - region is locked (L set and no bypass)
//   o_cfg_next - config to store (equals i_cfg_old when the write is dropped)
module ibex_pmp_cfg_legalise
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0
) (
    input  pmp_cfg_t   i_cfg_old,
    input  logic [7:0] i_cfg_new,
    input  logic       i_mml,
    input  logic       i_rlb,
    input  logic       i_locked,
    output pmp_cfg_t   o_cfg_next
);

    pmp_cfg_t w_req;
    logic     w_reserved_rw;
    logic     w_mml_block;

    always_comb begin
        w_req         = byte_to_cfg(i_cfg_new);
        w_reserved_rw = ~w_req.read & w_req.write;
        // Under MML, a locked executable non-shared region would be a new
        // M-only executable region; refuse it unless the bypass is active.
        w_mml_block   = i_mml & ~i_rlb & w_req.lock & w_req.exec & ~w_reserved_rw;

        // NA4 cannot be represented once the granule exceeds 4 bytes, so the
        // mode field keeps its old value while the permission bits still land.
        if ((PMPGranularity > 0) && (w_req.mode == PMP_MODE_NA4)) begin
            w_req.mode = i_cfg_old.mode;
        end

        o_cfg_next = w_req;
        if (i_locked || (w_reserved_rw && !i_mml) || w_mml_block) begin
            o_cfg_next = i_cfg_old;
        end
    end

endmodule

// File: rtl/ibex_pmp_csr.sv
// ibex_pmp_csr: machine-mode CSR back end for PMP. Holds pmpcfg0-3,
// pmpaddr0-15 and mseccfg/mseccfgh, applies the WARL/lock/MML/RLB write
// rules, answers reads over a single-outstanding req/gnt/rvalid handshake and
// requests a flush after any write that changed stored state.
// Optional feature: define PMP_CSR_RLB_EN to implement rule-locking bypass
// (mseccfg.rlb); otherwise rlb is hard-wired to 0.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   csr_req_i/we/addr/wdata - CSR access request from the CSR unit
//   csr_gnt_o               - request accepted (combinational in IDLE)
//   csr_rvalid_o            - one-cycle response strobe
//   csr_rdata_o, csr_err_o  - read data (post-write value for writes), bad address
//   pmp_flush_o/ack_i       - flush request to downstream and its completion
//   csr_pmp_cfg_o/addr_o    - per-region config and {pmpaddr, 2'b00} to the checker
//   csr_pmp_mseccfg_o       - mml/mmwp/rlb to the checker
module ibex_pmp_csr
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         csr_req_i,
    input  logic         csr_we_i,
    input  logic [11:0]  csr_addr_i,
    input  logic [31:0]  csr_wdata_i,
    output logic         csr_gnt_o,
    output logic         csr_rvalid_o,
    output logic [31:0]  csr_rdata_o,
    output logic         csr_err_o,
    output logic         pmp_flush_o,
    input  logic         pmp_flush_ack_i,
    output pmp_cfg_t     csr_pmp_cfg_o  [PMPNumRegions],
    output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
    output pmp_mseccfg_t csr_pmp_mseccfg_o
);

    // Read-back masks: OFF/TOR hide the low G bits, NAPOT shows the low G-1 as ones.
    localparam logic [31:0] TorMask   = 32'((64'd1 << PMPGranularity) - 64'd1);
    localparam logic [31:0] NapotMask = TorMask >> 1;

    pmp_csr_state_e r_state, w_state_nxt;

    pmp_cfg_t    r_cfg  [PMPNumRegions];
    logic [31:0] r_addr [PMPNumRegions];
    logic        r_mml;
    logic        r_mmwp;
`ifdef PMP_CSR_RLB_EN
    logic        r_rlb;
`endif
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_changed;

    pmp_cfg_t    w_cfg_leg [PMPNumRegions];
    pmp_cfg_t    w_cfg_nxt [PMPNumRegions];
    logic [31:0] w_addr_nxt [PMPNumRegions];
    logic [PMPNumRegions-1:0] w_lock_bits;
    logic [PMPNumRegions-1:0] w_locked;
    logic [PMPNumRegions-1:0] w_tor_lock;

    logic        w_rlb;
    logic        w_mml_nxt;
    logic        w_mmwp_nxt;
    logic        w_rlb_nxt;
    logic        w_commit;
    logic        w_msec_hit;
    logic        w_sel_cfg;
    logic        w_sel_addr;
    logic        w_sel_msec;
    logic        w_sel_msech;
    logic [31:0] w_rdata;
    logic        w_err;
    logic        w_changed;

    function automatic logic [31:0] addr_readback(input logic [31:0] a, input pmp_cfg_mode_e m);
        logic [31:0] v;
        v = a;
        if (m == PMP_MODE_NAPOT) begin
            v = a | NapotMask;
        end else if ((m == PMP_MODE_OFF) || (m == PMP_MODE_TOR)) begin
            v = a & ~TorMask;
        end
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_sel_cfg   = 1'b0;
        w_sel_addr  = 1'b0;
        w_sel_msec  = 1'b0;
        w_sel_msech = 1'b0;
        case (csr_addr_i)
            CSR_PMPCFG0, CSR_PMPCFG1, CSR_PMPCFG2, CSR_PMPCFG3: w_sel_cfg = 1'b1;
            CSR_PMPADDR0,  CSR_PMPADDR1,  CSR_PMPADDR2,  CSR_PMPADDR3,
            CSR_PMPADDR4,  CSR_PMPADDR5,  CSR_PMPADDR6,  CSR_PMPADDR7,
            CSR_PMPADDR8,  CSR_PMPADDR9,  CSR_PMPADDR10, CSR_PMPADDR11,
            CSR_PMPADDR12, CSR_PMPADDR13, CSR_PMPADDR14, CSR_PMPADDR15: w_sel_addr = 1'b1;
            CSR_MSECCFG:  w_sel_msec  = 1'b1;
            CSR_MSECCFGH: w_sel_msech = 1'b1;
            default: ;
        endcase
    end

    assign w_commit   = csr_gnt_o & csr_we_i;
    assign w_msec_hit = w_commit & w_sel_msec;

`ifdef PMP_CSR_RLB_EN
    logic w_any_lock;
    assign w_rlb      = r_rlb;
    assign w_any_lock = |w_lock_bits;
    // Once any region is locked, rlb can only be changed while already set.
    assign w_rlb_nxt  = (w_msec_hit & (r_rlb | ~w_any_lock)) ? csr_wdata_i[2] : r_rlb;
`else
    assign w_rlb      = 1'b0;
    assign w_rlb_nxt  = 1'b0;
`endif

    // mml and mmwp can be set by software but only cleared by reset.
    assign w_mml_nxt  = r_mml  | (w_msec_hit & csr_wdata_i[0]);
    assign w_mmwp_nxt = r_mmwp | (w_msec_hit & csr_wdata_i[1]);

    assign w_locked = w_lock_bits & ~{PMPNumRegions{w_rlb}};

    // ---------------------------------------------------------------------
    // Per-region next-state
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < int'(PMPNumRegions); i++) begin : g_region
        localparam logic [1:0] CfgCsr  = 2'(i / 4);
        localparam int unsigned ByteIdx = i % 4;

        logic w_cfg_hit;
        logic w_addr_hit;

        assign w_lock_bits[i] = r_cfg[i].lock;
        assign w_cfg_hit      = w_commit & w_sel_cfg & (csr_addr_i[1:0] == CfgCsr);
        assign w_addr_hit     = w_commit & w_sel_addr & (csr_addr_i[3:0] == 4'(i));

        ibex_pmp_cfg_legalise #(
            .PMPGranularity (PMPGranularity)
        ) u_legalise (
            .i_cfg_old  (r_cfg[i]),
            .i_cfg_new  (csr_wdata_i[8*ByteIdx +: 8]),
            .i_mml      (r_mml),
            .i_rlb      (w_rlb),
            .i_locked   (w_locked[i]),
            .o_cfg_next (w_cfg_leg[i])
        );

        assign w_cfg_nxt[i] = w_cfg_hit ? w_cfg_leg[i] : r_cfg[i];

        // A locked TOR region above also freezes this address, since it is
        // that region's lower bound.
        if (i < int'(PMPNumRegions) - 1) begin : g_tor
            assign w_tor_lock[i] = (r_cfg[i+1].mode == PMP_MODE_TOR) & w_locked[i+1];
        end else begin : g_last
            assign w_tor_lock[i] = 1'b0;
        end

        assign w_addr_nxt[i] = (w_addr_hit & ~w_locked[i] & ~w_tor_lock[i]) ? csr_wdata_i : r_addr[i];

        assign csr_pmp_cfg_o[i]  = r_cfg[i];
        assign csr_pmp_addr_o[i] = {r_addr[i], 2'b00};
    end

    assign csr_pmp_mseccfg_o = '{rlb: w_rlb, mmwp: r_mmwp, mml: r_mml};

    // ---------------------------------------------------------------------
    // Read mux and change detection. Both use next-state values, so a read
    // returns current storage and a write returns its legalised result.
    // ---------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_sel_cfg) begin
            for (int i = 0; i < int'(PMPNumRegions); i++) begin
                if ((i / 4) == int'(csr_addr_i[1:0])) begin
                    w_rdata[8*(i%4) +: 8] = cfg_to_byte(w_cfg_nxt[i]);
                end
            end
        end else if (w_sel_addr) begin
            for (int i = 0; i < int'(PMPNumRegions); i++) begin
                if (i == int'(csr_addr_i[3:0])) begin
                    w_rdata = addr_readback(w_addr_nxt[i], w_cfg_nxt[i].mode);
                end
            end
        end else if (w_sel_msec) begin
            w_rdata = {29'd0, w_rlb_nxt, w_mmwp_nxt, w_mml_nxt};
        end else if (!w_sel_msech) begin
            w_err = 1'b1;
        end
    end

    always_comb begin
        w_changed = (w_mml_nxt != r_mml) | (w_mmwp_nxt != r_mmwp) | (w_rlb_nxt != w_rlb);
        for (int i = 0; i < int'(PMPNumRegions); i++) begin
            w_changed = w_changed | (w_cfg_nxt[i] != r_cfg[i]) | (w_addr_nxt[i] != r_addr[i]);
        end
    end

    // ---------------------------------------------------------------------
    // Handshake FSM
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        csr_gnt_o    = 1'b0;
        csr_rvalid_o = 1'b0;
        pmp_flush_o  = 1'b0;
        case (r_state)
            PMP_CSR_IDLE: begin
                // Masked during reset so nothing is accepted on a reset edge.
                csr_gnt_o = csr_req_i & ~rst_i;
                if (csr_gnt_o) begin
                    w_state_nxt = PMP_CSR_RESP;
                end
            end
            PMP_CSR_RESP: begin
                csr_rvalid_o = 1'b1;
                w_state_nxt  = r_changed ? PMP_CSR_FLUSH : PMP_CSR_IDLE;
            end
            PMP_CSR_FLUSH: begin
                pmp_flush_o = 1'b1;
                if (pmp_flush_ack_i) begin
                    w_state_nxt = PMP_CSR_IDLE;
                end
            end
            default: w_state_nxt = PMP_CSR_IDLE;
        endcase
    end

    assign csr_rdata_o = (r_state == PMP_CSR_RESP) ? r_rdata : 32'd0;
    assign csr_err_o   = (r_state == PMP_CSR_RESP) & r_err;

    // ---------------------------------------------------------------------
    // State and storage registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= PMP_CSR_IDLE;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_changed <= 1'b0;
            r_mml     <= 1'b0;
            r_mmwp    <= 1'b0;
`ifdef PMP_CSR_RLB_EN
            r_rlb     <= 1'b0;
`endif
            for (int i = 0; i < int'(PMPNumRegions); i++) begin
                r_cfg[i]  <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (csr_gnt_o) begin
                r_rdata   <= w_rdata;
                r_err     <= w_err;
                r_changed <= w_changed;
            end
            r_mml  <= w_mml_nxt;
            r_mmwp <= w_mmwp_nxt;
`ifdef PMP_CSR_RLB_EN
            r_rlb  <= w_rlb_nxt;
`endif
            for (int i = 0; i < int'(PMPNumRegions); i++) begin
                r_cfg[i]  <= w_cfg_nxt[i];
                r_addr[i] <= w_addr_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_ibex_pmp_csr.sv
`timescale 1ns/1ps
module tb_ibex_pmp_csr;
    import ibex_pkg::*;

    localparam int TB_G = 2;
    localparam int TB_N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic we = 1'b0;
    logic ack = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic gnt, rvalid, err, flush;
    logic [31:0] rdata;
    pmp_cfg_t     cfg_o  [TB_N];
    logic [33:0]  addr_o [TB_N];
    pmp_mseccfg_t msec_o;

    int n_cmp = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // Architectural model: raw cfg bytes, raw pmpaddr words, mseccfg bits.
    logic [7:0]  m_cfg  [TB_N];
    logic [31:0] m_addr [TB_N];
    logic m_mml, m_mmwp, m_rlb;

    always #5 clk = ~clk;

    ibex_pmp_csr #(.PMPGranularity(TB_G), .PMPNumRegions(TB_N)) dut (
        .clk_i(clk), .rst_i(rst), .csr_req_i(req), .csr_we_i(we),
        .csr_addr_i(addr), .csr_wdata_i(wdata), .csr_gnt_o(gnt),
        .csr_rvalid_o(rvalid), .csr_rdata_o(rdata), .csr_err_o(err),
        .pmp_flush_o(flush), .pmp_flush_ack_i(ack),
        .csr_pmp_cfg_o(cfg_o), .csr_pmp_addr_o(addr_o), .csr_pmp_mseccfg_o(msec_o)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < TB_N; i++) begin
            m_cfg[i] = 8'h00;
            m_addr[i] = 32'h0;
        end
        m_mml = 0; m_mmwp = 0; m_rlb = 0;
    endfunction

    function automatic bit m_locked(input int i);
        return m_cfg[i][7] && !m_rlb;
    endfunction

    function automatic logic [7:0] cfg_write(input int i, input logic [7:0] nb);
        logic [7:0] old;
        logic [1:0] a;
        old = m_cfg[i];
        if (m_locked(i)) return old;
        if (!m_mml && !nb[0] && nb[1]) return old;
        if (m_mml && !m_rlb && nb[7] && nb[2] && !(!nb[0] && nb[1])) return old;
        a = nb[4:3];
        if (TB_G > 0 && a == 2'b10) a = old[4:3];
        return {nb[7], 2'b00, a, nb[2:0]};
    endfunction

    function automatic logic [31:0] readback(input int i);
        logic [31:0] g_bytes;
        g_bytes = (32'd1 << TB_G) - 1;
        case (m_cfg[i][4:3])
            2'b11:   return m_addr[i] | (g_bytes >> 1);
            2'b10:   return m_addr[i];
            default: return m_addr[i] & ~g_bytes;
        endcase
    endfunction

    function automatic void model_access(input bit w, input logic [11:0] a, input logic [31:0] d,
                                         output logic [31:0] rd, output bit e, output bit chg);
        logic [7:0]  sv_cfg [TB_N];
        logic [31:0] sv_addr [TB_N];
        logic [2:0]  sv_sec;
        int k;
        for (int i = 0; i < TB_N; i++) begin sv_cfg[i] = m_cfg[i]; sv_addr[i] = m_addr[i]; end
        sv_sec = {m_rlb, m_mmwp, m_mml};
        rd = 0; e = 0;
        if (a >= 12'h3A0 && a <= 12'h3A3) begin
            k = int'(a - 12'h3A0);
            for (int b = 0; b < 4; b++) begin
                if (4*k + b < TB_N) begin
                    if (w) m_cfg[4*k+b] = cfg_write(4*k+b, d[8*b +: 8]);
                    rd[8*b +: 8] = m_cfg[4*k+b];
                end
            end
        end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
            k = int'(a - 12'h3B0);
            if (k < TB_N) begin
                if (w && !m_locked(k) &&
                    !(k + 1 < TB_N && m_cfg[k+1][4:3] == 2'b01 && m_locked(k+1)))
                    m_addr[k] = d;
                rd = readback(k);
            end
        end else if (a == 12'h747) begin
            if (w) begin
`ifdef PMP_CSR_RLB_EN
                bit any_l;
                any_l = 0;
                for (int i = 0; i < TB_N; i++) any_l |= m_cfg[i][7];
                if (m_rlb || !any_l) m_rlb = d[2];
`endif
                m_mml  = m_mml | d[0];
                m_mmwp = m_mmwp | d[1];
            end
            rd = {29'd0, m_rlb, m_mmwp, m_mml};
        end else if (a != 12'h757) begin
            e = 1;
        end
        chg = (sv_sec != {m_rlb, m_mmwp, m_mml});
        for (int i = 0; i < TB_N; i++)
            if (sv_cfg[i] != m_cfg[i] || sv_addr[i] != m_addr[i]) chg = 1;
    endfunction

    // Storage outputs against the model, every cycle once out of first reset.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < TB_N; i++) begin
                check($sformatf("cfg_o[%0d]", i),
                      {cfg_o[i].lock, 2'b00, cfg_o[i].mode, cfg_o[i].exec, cfg_o[i].write, cfg_o[i].read},
                      m_cfg[i]);
                check($sformatf("addr_o[%0d]", i), addr_o[i], {m_addr[i], 2'b00});
            end
            check("mseccfg_o", msec_o, {m_rlb, m_mmwp, m_mml});
        end
    end

    // One access. ack_dly >= 0: flush acknowledged after that many extra
    // cycles; ack_dly < 0: reset is applied during the flush instead.
    task automatic access(input bit w, input logic [11:0] a, input logic [31:0] d, input int ack_dly,
                          output logic [31:0] act_rd, output logic act_err);
        logic [31:0] e_rd;
        bit e_err, e_chg;
        @(negedge clk); #1;
        req = 1; we = w; addr = a; wdata = d;
        #1;
        check($sformatf("gnt@%h", a), gnt, 1'b1);
        check("rvalid_idle", rvalid, 1'b0);
        model_access(w, a, d, e_rd, e_err, e_chg);
        @(negedge clk); #1;
        req = 0; we = 0; ack = 1;  // stray ack outside FLUSH must be ignored
        #1;
        act_rd = rdata; act_err = err;
        check($sformatf("rvalid@%h", a), rvalid, 1'b1);
        check($sformatf("rdata@%h", a), rdata, e_rd);
        check($sformatf("err@%h", a), err, e_err);
        check("gnt_resp", gnt, 1'b0);
        check("flush_resp", flush, 1'b0);
        @(negedge clk); #1;
        ack = 0;
        #1;
        check("rvalid_once", rvalid, 1'b0);
        check($sformatf("flush_after@%h", a), flush, e_chg);
        if (e_chg && ack_dly < 0) begin
            rst = 1; req = 1; addr = 12'h3A0;
            model_reset();
            @(negedge clk); #1;
            check("flush_rst", flush, 1'b0);
            check("gnt_rst", gnt, 1'b0);
            check("rvalid_rst", rvalid, 1'b0);
            rst = 0; req = 0;
            @(negedge clk); #1;
            check("flush_post_rst", flush, 1'b0);
            check("rvalid_post_rst", rvalid, 1'b0);
        end else if (e_chg) begin
            for (int k = 0; k < ack_dly; k++) begin
                req = 1; we = 0; addr = 12'h3A0;
                #1;
                check("flush_hold", flush, 1'b1);
                check("gnt_in_flush", gnt, 1'b0);
                @(negedge clk); #1;
            end
            req = 0; ack = 1;
            #1;
            check("flush_ackcyc", flush, 1'b1);
            @(negedge clk); #1;
            ack = 0;
            #1;
            check("flush_done", flush, 1'b0);
            check("rvalid_after_flush", rvalid, 1'b0);
        end
    endtask

    task automatic txn(input string nm, input bit w, input logic [11:0] a, input logic [31:0] d,
                       input int ack_dly, input logic [31:0] pin_rd, input logic pin_err);
        logic [31:0] r;
        logic e;
        access(w, a, d, ack_dly, r, e);
        check({"pin_rd_", nm}, r, pin_rd);
        check({"pin_err_", nm}, e, pin_err);
    endtask

    initial begin
        model_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", gnt, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        rst = 0;
        started = 1;

        txn("rd_cfg0",    0, 12'h3A0, 32'h0,         0, 32'h0000_0000, 0);
        txn("wr_cfg_f07", 1, 12'h3A0, 32'h0000_0F07, 3, 32'h0000_0F07, 0);
        txn("napot_cfg",  1, 12'h3A0, 32'h0000_0F19, 1, 32'h0000_0F19, 0);
        txn("napot_addr", 1, 12'h3B0, 32'h0000_1000, 0, 32'h0000_1001, 0);
        txn("napot_rd",   0, 12'h3B0, 32'h0,         0, 32'h0000_1001, 0);
        txn("off_cfg",    1, 12'h3A0, 32'h0000_0F01, 0, 32'h0000_0F01, 0);
        txn("off_rd",     0, 12'h3B0, 32'h0,         0, 32'h0000_1000, 0);
        txn("na4_illegal",1, 12'h3A0, 32'h0000_0F13, 0, 32'h0000_0F03, 0);
        txn("rsvd_rw",    1, 12'h3A0, 32'h0000_0F02, 0, 32'h0000_0F03, 0);
        txn("bits65",     1, 12'h3A0, 32'h0000_0F63, 0, 32'h0000_0F03, 0);
        txn("lock_cfg",   1, 12'h3A0, 32'h008F_008F, 2, 32'h008F_008F, 0);
        txn("lock_addr0", 1, 12'h3B0, 32'h0000_1234, 0, 32'h0000_1000, 0);
        txn("torlock_a1", 1, 12'h3B1, 32'h0000_5678, 0, 32'h0000_0000, 0);
        txn("lock_addr2", 1, 12'h3B2, 32'h0000_ABCD, 0, 32'h0000_0000, 0);
        txn("addr3_ok",   1, 12'h3B3, 32'h0000_2222, 0, 32'h0000_2220, 0);
        txn("cfg_same",   1, 12'h3A0, 32'h0000_0000, 0, 32'h008F_008F, 0);
        txn("unimpl_cfg", 1, 12'h3A1, 32'hFFFF_FFFF, 0, 32'h0000_0000, 0);
        txn("unimpl_addr",0, 12'h3BF, 32'h0,         0, 32'h0000_0000, 0);
        txn("msech",      1, 12'h757, 32'hFFFF_FFFF, 0, 32'h0000_0000, 0);
        txn("bad_rd",     0, 12'h3C0, 32'h0,         0, 32'h0000_0000, 1);
        txn("bad_wr",     1, 12'h7C0, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1);
        txn("mml_set",    1, 12'h747, 32'h0000_0001, 1, 32'h0000_0001, 0);
        txn("mml_sticky", 1, 12'h747, 32'h0000_0000, 0, 32'h0000_0001, 0);
        txn("mmwp_set",   1, 12'h747, 32'h0000_0002, 0, 32'h0000_0003, 0);
        txn("mml_8d",     1, 12'h3A0, 32'h8D00_0000, 0, 32'h008F_008F, 0);
        txn("mml_shared", 1, 12'h3A0, 32'h0A00_0000, 0, 32'h0A8F_008F, 0);
        txn("rlb_locked", 1, 12'h747, 32'h0000_0004, 0, 32'h0000_0003, 0);
        txn("addr3_tor",  1, 12'h3B3, 32'h0000_3333, -1, 32'h0000_3330, 0);
        txn("msec_rst",   0, 12'h747, 32'h0,         0, 32'h0000_0000, 0);
        txn("cfg_rst",    0, 12'h3A0, 32'h0,         0, 32'h0000_0000, 0);
`ifdef PMP_CSR_RLB_EN
        txn("rlb_set",    1, 12'h747, 32'h0000_0004, 0, 32'h0000_0004, 0);
        txn("rlb_mml",    1, 12'h747, 32'h0000_0005, 0, 32'h0000_0005, 0);
        txn("rlb_8d",     1, 12'h3A0, 32'h0000_008D, 0, 32'h0000_008D, 0);
        txn("rlb_unlock", 1, 12'h3A0, 32'h0000_0000, 0, 32'h0000_0000, 0);
        txn("rlb_l80",    1, 12'h3A0, 32'h0000_0080, 0, 32'h0000_0080, 0);
        txn("rlb_clear",  1, 12'h747, 32'h0000_0000, 0, 32'h0000_0001, 0);
        txn("rlb_noset",  1, 12'h747, 32'h0000_0004, 0, 32'h0000_0001, 0);
        txn("rlb_relock", 1, 12'h3A0, 32'h0000_0000, 0, 32'h0000_0080, 0);
`else
        txn("rlb_hw0",    1, 12'h747, 32'h0000_0004, 0, 32'h0000_0000, 0);
        txn("mml_set2",   1, 12'h747, 32'h0000_0001, 0, 32'h0000_0001, 0);
        txn("mml_8d_2",   1, 12'h3A0, 32'h0000_008D, 0, 32'h0000_0000, 0);
`endif
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
